// File: rtl/itr_ctrl_if.sv
// Core-facing handshake of the vectored interrupt controller.
interface itr_ctrl_if #(
   parameter int unsigned MINSTW = 9
);
   logic              itr_req;
   logic [MINSTW-1:0] itr_vec;
   logic              itr_ack;
   logic [MINSTW-1:0] pc_addr;
   logic              reti;
   logic [MINSTW-1:0] ret_addr;
   logic              itr_act;
   logic              itr_err;

   // Controller side
   modport slave (
      output itr_req, itr_vec, ret_addr, itr_act, itr_err,
      input  itr_ack, pc_addr, reti
   );

   // Processor core side
   modport master (
      input  itr_req, itr_vec, ret_addr, itr_act, itr_err,
      output itr_ack, pc_addr, reti
   );
endinterface

// File: rtl/itr_ctrl.sv
// Multi-channel vectored interrupt controller with prioritised sources,
// enable mask, per-channel vectors and a nested return-address stack.
module itr_ctrl #(
   parameter int unsigned NITR    = 4,
   parameter int unsigned MINSTW  = 9,
   parameter int unsigned ITRBASE = 1,
   parameter int unsigned ITRSTP  = 4,
   parameter int unsigned NDEPTH  = 2,
   parameter int unsigned EDGE    = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NITR-1:0] itr_in,
   input  logic            msk_wr,
   input  logic [NITR-1:0] msk_in,
   output logic [NITR-1:0] msk_out,
   itr_ctrl_if.slave       core
);

   localparam int unsigned CW = (NITR > 1) ? $clog2(NITR) : 1;
   localparam int unsigned DW = $clog2(NDEPTH + 1);

   logic [NITR-1:0]   pending;
   logic [NITR-1:0]   mask;
   logic [NITR-1:0]   prev;
   logic [NITR-1:0]   trig;
   logic [NITR-1:0]   cand_oh;
   logic              cand_vld;
   logic [CW-1:0]     cand_idx;
   logic [MINSTW-1:0] stk_addr [NDEPTH];
   logic [CW-1:0]     stk_ch   [NDEPTH];
   logic [DW-1:0]     depth;
   logic [DW-1:0]     top;
   logic [MINSTW-1:0] top_addr;
   logic [CW-1:0]     top_ch;
   logic              empty;
   logic              full;
   logic              req;
   logic              accept;
   logic              pop;
   logic              err;

   // Lowest-index enabled pending channel wins
   always_comb begin
      cand_vld = 1'b0;
      cand_idx = '0;
      cand_oh  = '0;
      for (int i = NITR - 1; i >= 0; i--) begin
         if (pending[i] && mask[i]) begin
            cand_vld   = 1'b1;
            cand_idx   = CW'(i);
            cand_oh    = '0;
            cand_oh[i] = 1'b1;
         end
      end
   end

   // Top-of-stack read; zero when the stack is empty
   always_comb begin
      top      = depth - DW'(1);
      top_addr = '0;
      top_ch   = '0;
      for (int i = 0; i < NDEPTH; i++) begin
         if (!empty && (DW'(i) == top)) begin
            top_addr = stk_addr[i];
            top_ch   = stk_ch[i];
         end
      end
   end

   assign empty  = (depth == '0);
   assign full   = (depth == DW'(NDEPTH));
   // Only a strictly higher-priority channel may preempt the one in service
   assign req    = cand_vld && !full && (empty || (cand_idx < top_ch));
   assign trig   = (EDGE != 0) ? (itr_in & ~prev) : itr_in;
   // A simultaneous reti takes precedence and the ack is dropped
   assign accept = core.itr_ack && req && !core.reti;
   assign pop    = core.reti && !empty;

   assign core.itr_req  = req;
   assign core.itr_vec  = MINSTW'(ITRBASE + ITRSTP * 32'(cand_idx));
   assign core.ret_addr = top_addr;
   assign core.itr_act  = !empty;
   assign core.itr_err  = err;
   assign msk_out       = mask;

   // Pending capture, mask register, return stack and sticky error
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
         mask    <= '0;
         prev    <= '0;
         depth   <= '0;
         err     <= 1'b0;
         for (int i = 0; i < NDEPTH; i++) begin
            stk_addr[i] <= '0;
            stk_ch[i]   <= '0;
         end
      end else begin
         prev <= itr_in;
         if (msk_wr) begin
            mask <= msk_in;
         end
         // New trigger on the accepted channel overrides the clear
         pending <= (pending & ~({NITR{accept}} & cand_oh)) | trig;
         if (pop) begin
            depth <= depth - DW'(1);
         end else if (accept) begin
            depth <= depth + DW'(1);
         end
         for (int i = 0; i < NDEPTH; i++) begin
            if (accept && (DW'(i) == depth)) begin
               stk_addr[i] <= core.pc_addr;
               stk_ch[i]   <= cand_idx;
            end
         end
         if (core.reti && (empty || core.itr_ack)) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_itr_ctrl.sv
// Self-checking bench for itr_ctrl: vector table through a scoreboard queue
// plus hand-written sequences for reset, sticky error and edge behaviour.
module tb_itr_ctrl;

   localparam int unsigned NITR = 4;
   localparam int unsigned MW   = 9;

   typedef struct {
      logic [NITR-1:0] itr;
      logic            mwr;
      logic [NITR-1:0] msk;
      logic            ack;
      logic [MW-1:0]   pc;
      logic            reti;
      logic            req;
      logic [MW-1:0]   vec;
      logic [MW-1:0]   ret;
      logic            act;
      logic            err;
      logic [NITR-1:0] mo;
   } vec_t;

   logic            clk;
   logic            rst;
   logic [NITR-1:0] itr_in;
   logic            msk_wr;
   logic [NITR-1:0] msk_in;
   logic [NITR-1:0] msk_out;

   itr_ctrl_if #(.MINSTW(MW)) bus ();

   itr_ctrl #(
      .NITR(NITR), .MINSTW(MW), .ITRBASE(1), .ITRSTP(4), .NDEPTH(2), .EDGE(1)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .itr_in  (itr_in),
      .msk_wr  (msk_wr),
      .msk_in  (msk_in),
      .msk_out (msk_out),
      .core    (bus)
   );

   vec_t vt[$];
   vec_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic add(input logic [NITR-1:0] itr, input logic mwr, input logic [NITR-1:0] msk,
                      input logic ack, input logic [MW-1:0] pc, input logic reti,
                      input logic req, input logic [MW-1:0] vec, input logic [MW-1:0] ret,
                      input logic act, input logic err, input logic [NITR-1:0] mo);
      vec_t v;
      v.itr = itr; v.mwr = mwr; v.msk = msk; v.ack = ack; v.pc = pc; v.reti = reti;
      v.req = req; v.vec = vec; v.ret = ret; v.act = act; v.err = err; v.mo = mo;
      vt.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      itr_in      = v.itr;
      msk_wr      = v.mwr;
      msk_in      = v.msk;
      bus.itr_ack = v.ack;
      bus.pc_addr = v.pc;
      bus.reti    = v.reti;
   endtask

   task automatic idle();
      itr_in      = '0;
      msk_wr      = 1'b0;
      msk_in      = '0;
      bus.itr_ack = 1'b0;
      bus.pc_addr = '0;
      bus.reti    = 1'b0;
   endtask

   task automatic chk_out(input string nm, input logic req, input logic [MW-1:0] vec,
                          input logic [MW-1:0] ret, input logic act, input logic err,
                          input logic [NITR-1:0] mo);
      chk({nm, ".req"}, 32'(bus.itr_req), 32'(req));
      chk({nm, ".vec"}, 32'(bus.itr_vec), 32'(vec));
      chk({nm, ".ret"}, 32'(bus.ret_addr), 32'(ret));
      chk({nm, ".act"}, 32'(bus.itr_act), 32'(act));
      chk({nm, ".err"}, 32'(bus.itr_err), 32'(err));
      chk({nm, ".msk"}, 32'(msk_out), 32'(mo));
   endtask

   initial begin
      vec_t e;
      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1;
      chk_out("reset", 1'b0, 9'd1, 9'd0, 1'b0, 1'b0, 4'b0000);
      @(negedge clk);
      rst = 1'b0;

      //  itr      mwr msk      ack pc  reti | req vec ret act err mask
      add(4'b0000, 1, 4'b1111, 0, 0,  0,     0,  1,  0,  0,  0, 4'b1111); // enable all
      add(4'b0100, 0, 4'b0000, 0, 0,  0,     1,  9,  0,  0,  0, 4'b1111); // ch2 pulse
      add(4'b0000, 0, 4'b0000, 1, 37, 0,     0,  1,  37, 1,  0, 4'b1111); // ack ch2
      add(4'b0000, 0, 4'b0000, 0, 0,  1,     0,  1,  0,  0,  0, 4'b1111); // reti
      add(4'b1010, 0, 4'b0000, 0, 0,  0,     1,  5,  0,  0,  0, 4'b1111); // ch1+ch3
      add(4'b0000, 0, 4'b0000, 1, 20, 0,     0,  13, 20, 1,  0, 4'b1111); // ack ch1
      add(4'b0000, 0, 4'b0000, 0, 0,  1,     1,  13, 0,  0,  0, 4'b1111); // reti -> ch3 req
      add(4'b0000, 0, 4'b0000, 1, 30, 0,     0,  1,  30, 1,  0, 4'b1111); // ack ch3
      add(4'b0000, 0, 4'b0000, 0, 0,  1,     0,  1,  0,  0,  0, 4'b1111); // reti
      add(4'b0100, 0, 4'b0000, 0, 0,  0,     1,  9,  0,  0,  0, 4'b1111); // ch2
      add(4'b0000, 0, 4'b0000, 1, 40, 0,     0,  1,  40, 1,  0, 4'b1111); // ack ch2
      add(4'b1000, 0, 4'b0000, 0, 0,  0,     0,  13, 40, 1,  0, 4'b1111); // ch3 no preempt
      add(4'b0001, 0, 4'b0000, 0, 0,  0,     1,  1,  40, 1,  0, 4'b1111); // ch0 preempts
      add(4'b0000, 0, 4'b0000, 1, 50, 0,     0,  13, 50, 1,  0, 4'b1111); // ack ch0
      add(4'b0000, 0, 4'b0000, 0, 0,  1,     0,  13, 40, 1,  0, 4'b1111); // LIFO pop 50
      add(4'b0000, 0, 4'b0000, 0, 0,  1,     1,  13, 0,  0,  0, 4'b1111); // LIFO pop 40
      add(4'b0000, 0, 4'b0000, 1, 60, 0,     0,  1,  60, 1,  0, 4'b1111); // ack ch3
      add(4'b0000, 0, 4'b0000, 0, 0,  1,     0,  1,  0,  0,  0, 4'b1111); // reti
      add(4'b0000, 1, 4'b0000, 0, 0,  0,     0,  1,  0,  0,  0, 4'b0000); // mask off
      add(4'b0010, 0, 4'b0000, 0, 0,  0,     0,  1,  0,  0,  0, 4'b0000); // ch1 masked
      add(4'b0000, 1, 4'b0010, 0, 0,  0,     1,  5,  0,  0,  0, 4'b0010); // unmask ch1
      add(4'b0000, 0, 4'b0000, 1, 70, 0,     0,  1,  70, 1,  0, 4'b0010); // ack ch1
      add(4'b0000, 1, 4'b1111, 0, 0,  1,     0,  1,  0,  0,  0, 4'b1111); // reti, mask all
      add(4'b0100, 0, 4'b0000, 0, 0,  0,     1,  9,  0,  0,  0, 4'b1111); // ch2
      add(4'b0000, 0, 4'b0000, 1, 81, 0,     0,  1,  81, 1,  0, 4'b1111); // ack ch2
      add(4'b0010, 0, 4'b0000, 0, 0,  0,     1,  5,  81, 1,  0, 4'b1111); // ch1 preempts
      add(4'b0000, 0, 4'b0000, 1, 82, 0,     0,  1,  82, 1,  0, 4'b1111); // ack ch1, full
      add(4'b0001, 0, 4'b0000, 0, 0,  0,     0,  1,  82, 1,  0, 4'b1111); // ch0 held: full
      add(4'b0000, 0, 4'b0000, 0, 0,  0,     0,  1,  82, 1,  0, 4'b1111); // still held
      add(4'b0000, 0, 4'b0000, 0, 0,  1,     1,  1,  81, 1,  0, 4'b1111); // reti frees slot
      add(4'b0000, 0, 4'b0000, 1, 83, 0,     0,  1,  83, 1,  0, 4'b1111); // ack ch0
      add(4'b0000, 0, 4'b0000, 0, 0,  1,     0,  1,  81, 1,  0, 4'b1111); // reti
      add(4'b0010, 0, 4'b0000, 0, 0,  0,     1,  5,  81, 1,  0, 4'b1111); // ch1 request
      add(4'b0000, 0, 4'b0000, 1, 99, 1,     1,  5,  0,  0,  1, 4'b1111); // ack+reti: err
      add(4'b0000, 0, 4'b0000, 1, 84, 0,     0,  1,  84, 1,  1, 4'b1111); // ack ch1
      add(4'b0000, 0, 4'b0000, 0, 0,  1,     0,  1,  0,  0,  1, 4'b1111); // reti
      add(4'b0100, 0, 4'b0000, 0, 0,  0,     1,  9,  0,  0,  1, 4'b1111); // ch2
      add(4'b0000, 0, 4'b0000, 0, 0,  0,     1,  9,  0,  0,  1, 4'b1111); // ch2 waits
      add(4'b0100, 0, 4'b0000, 1, 90, 0,     0,  9,  90, 1,  1, 4'b1111); // ack + retrigger
      add(4'b0000, 0, 4'b0000, 0, 0,  1,     1,  9,  0,  0,  1, 4'b1111); // retrigger kept
      add(4'b0000, 0, 4'b0000, 1, 91, 0,     0,  1,  91, 1,  1, 4'b1111); // ack ch2
      add(4'b0000, 0, 4'b0000, 0, 0,  1,     0,  1,  0,  0,  1, 4'b1111); // reti

      for (int i = 0; i < vt.size(); i++) begin
         @(negedge clk);
         drive(vt[i]);
         sb.push_back(vt[i]);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         chk_out($sformatf("s%0d", i + 1), e.req, e.vec, e.ret, e.act, e.err, e.mo);
      end

      // Asynchronous reset while channel 0 is in service
      @(negedge clk);
      idle();
      itr_in = 4'b0001;
      @(negedge clk);
      itr_in      = 4'b0000;
      bus.itr_ack = 1'b1;
      bus.pc_addr = 9'h055;
      @(negedge clk);
      idle();
      chk("svc.act", 32'(bus.itr_act), 32'd1);
      chk("svc.ret", 32'(bus.ret_addr), 32'h055);
      #2;
      rst = 1'b1;
      #1;
      chk_out("async_rst", 1'b0, 9'd1, 9'd0, 1'b0, 1'b0, 4'b0000);
      @(negedge clk);
      rst = 1'b0;

      // reti on an empty stack sets a sticky error
      @(negedge clk);
      bus.reti = 1'b1;
      @(negedge clk);
      bus.reti = 1'b0;
      chk("empty_reti.err", 32'(bus.itr_err), 32'd1);
      chk("empty_reti.act", 32'(bus.itr_act), 32'd0);
      repeat (3) @(negedge clk);
      chk("sticky.err", 32'(bus.itr_err), 32'd1);

      // A held-high source triggers only once
      msk_wr = 1'b1;
      msk_in = 4'b1111;
      itr_in = 4'b0100;
      @(negedge clk);
      msk_wr = 1'b0;
      chk("hold.req", 32'(bus.itr_req), 32'd1);
      chk("hold.vec", 32'(bus.itr_vec), 32'd9);
      bus.itr_ack = 1'b1;
      bus.pc_addr = 9'd5;
      @(negedge clk);
      bus.itr_ack = 1'b0;
      chk("hold.ack_req", 32'(bus.itr_req), 32'd0);
      chk("hold.ack_ret", 32'(bus.ret_addr), 32'd5);
      @(negedge clk);
      chk("hold.no_retrig", 32'(bus.itr_vec), 32'd1);
      itr_in   = 4'b0000;
      bus.reti = 1'b1;
      @(negedge clk);
      bus.reti = 1'b0;
      chk("hold.act", 32'(bus.itr_act), 32'd0);
      chk("hold.req_end", 32'(bus.itr_req), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/itr_ctrl.md
Name: itr_ctrl

Overview:
- Multi-channel vectored interrupt controller for the floating-point processor core.
- Replaces the single `itr` line and fixed interrupt address with NITR prioritised sources, a per-channel enable mask, per-channel vectors and nested return-address storage.
- Sits between external interrupt sources and the program counter/prefetch logic.
- The core loads `itr_vec` on acknowledge and loads `ret_addr` on return-from-interrupt.

Parameters:
- NITR, 4: number of interrupt channels; channel 0 has highest priority.
- MINSTW, 9: instruction address width.
- ITRBASE, 1: vector address of channel 0.
- ITRSTP, 4: vector spacing between channels.
- NDEPTH, 2: maximum nesting depth (return-stack entries), at least 1.
- EDGE, 1: 1 = rising-edge triggered sources; 0 = level triggered.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- itr_in  in  NITR  interrupt sources, synchronous to clk
- msk_wr  in  1  mask write strobe
- msk_in  in  NITR  new mask value (bit = 1 enables the channel)
- msk_out  out  NITR  current mask register
- itr_req  out  1  interrupt request to the core
- itr_vec  out  MINSTW  vector of the requested channel
- itr_ack  in  1  core accepts the request this cycle
- pc_addr  in  MINSTW  return address, sampled on accepted ack
- reti  in  1  return-from-interrupt strobe
- ret_addr  out  MINSTW  return address at top of stack (0 when empty)
- itr_act  out  1  at least one interrupt is in service
- itr_err  out  1  sticky error flag

Behaviour:
- Reset (asynchronous): pending = 0, mask = 0, stack empty, edge-history registers = 0, itr_err = 0. Outputs follow: itr_req = 0, itr_vec = ITRBASE, ret_addr = 0, itr_act = 0.
- Pending capture:
  - EDGE = 1: pending[i] is set at a clock edge where itr_in[i] = 1 and the previous sample was 0.
  - EDGE = 0: pending[i] is set whenever itr_in[i] = 1.
  - Pending bits latch even while the channel is masked.
- Mask: on msk_wr, the mask register takes msk_in at the clock edge. The mask gates the request only, never pending capture.
- Candidate channel: lowest index i with pending[i] & mask[i].
- itr_req = 1 when all of the following hold:
  - a candidate exists;
  - the stack is not full;
  - either the stack is empty, or the candidate index is strictly less than the channel index stored at the top of the stack (preemption by higher priority only).
- itr_req, itr_vec and ret_addr are driven combinationally from registers only; there is no combinational input-to-output path.
  - Latency: itr_in rise at edge k gives itr_req high after edge k+1 (one edge to capture pending).
- itr_vec = (ITRBASE + candidate*ITRSTP) mod 2^MINSTW. It is ITRBASE when there is no candidate.
- Accept: itr_ack & itr_req at a clock edge.
  - Push {pc_addr, candidate index}.
  - Clear pending[candidate].
  - If the same channel sees a new trigger in the same cycle, set wins and pending stays 1.
- itr_ack with itr_req = 0: ignored.
- reti with a non-empty stack: pop. ret_addr is valid from the cycle reti is asserted (top of stack before the pop).
- reti with an empty stack: ignored; set itr_err.
- itr_ack and reti in the same cycle:
  - Process reti only; ignore the ack; set itr_err.
  - itr_req is re-evaluated against the new top after the edge.
- Stack full with a candidate pending: itr_req stays 0; no error is raised (the request waits).
- itr_act = stack not empty.
- itr_err clears only on rst.
- Stack depth counter is $clog2(NDEPTH+1) bits and must not wrap.

Test Plan:
- Reset, then msk_in=4'b1111 with msk_wr; pulse itr_in[2] for 1 cycle -> itr_req=1 one edge later; itr_vec=9; ack with pc_addr=37 -> itr_req=0, itr_act=1, ret_addr=37.
- Simultaneous rise on itr_in[1] and itr_in[3] -> itr_vec=5 first; ack; reti -> ret_addr popped, itr_req=1 with itr_vec=13.
- In service on channel 2: raise itr_in[3] -> no itr_req. Raise itr_in[0] -> itr_req, itr_vec=1; ack with pc_addr=50 -> ret_addr=50. Two retis -> addresses returned in LIFO order, itr_act=0.
- Mask 0 while itr_in[1] rises -> itr_req=0. Write mask bit 1 -> itr_req=1 next cycle (pending retained).
- NDEPTH=2, two nested accepts, then channel 0 pending -> itr_req held 0 until one reti, then 1.
- reti on empty stack -> itr_err=1 and stays 1. Assert rst mid-service -> all outputs return to reset values immediately.
